// File: rtl/subleq_program_loader_pkg.sv
// Shared definitions for the SUBLEQ boot loader: state encoding, word geometry
// and the running-checksum helper.
package subleq_program_loader_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } loader_state_e;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // States in which the loader is consuming frame bytes
    function automatic logic is_stream_state(input loader_state_e s);
        logic r;
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/subleq_program_loader_byte_packer.sv
// Holds the high byte of a big-endian word and emits the full word with a
// one-cycle valid pulse in the cycle after the low byte is accepted.
module loader_byte_packer
    import subleq_program_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hi_load,
    input  logic                  lo_load,
    input  logic [7:0]            byte_in,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid
);

    logic [7:0]            hi_q, hi_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;

    // Next-value logic: latch W_HI, assemble the word on W_LO
    always_comb begin
        hi_d    = hi_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (hi_load) begin
            hi_d = byte_in;
        end else begin
            hi_d = hi_q;
        end
        if (lo_load) begin
            word_d  = WORD_WIDTH'({hi_q, byte_in});
            valid_d = 1'b1;
        end else begin
            word_d  = word_q;
            valid_d = 1'b0;
        end
    end

    // Packer registers; reset drops any pending valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= 8'h00;
            word_q  <= {WORD_WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/subleq_program_loader.sv
// Boot loader: parses a length/data/checksum byte frame, writes the words into
// processor RAM and keeps the processor held until a load passes its checksum.
module subleq_program_loader
    import subleq_program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    // Largest word count that still fits between BASE_ADDR and the top of RAM
    localparam logic [31:0] LEN_LIMIT = 32'((2 ** ADDR_WIDTH) - BASE_ADDR);

    loader_state_e         state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic                  accept_s;
    logic                  start_ok_s;
    logic [15:0]           len_word_s;
    logic                  len_too_big_s;
    logic [15:0]           cnt_next_s;
    logic [7:0]            sum_next_s;

    assign accept_s      = in_valid & in_ready_q;
    assign start_ok_s    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERROR));
    assign len_word_s    = {len_hi_q, in_data};
    assign len_too_big_s = ({16'h0000, len_word_s} > LEN_LIMIT);
    assign cnt_next_s    = cnt_q + 16'd1;
    assign sum_next_s    = csum_add(sum_q, in_data);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; advances only on accepted bytes or an honoured start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_LEN_HI;
                else       state_d = state_q;
            end
            ST_LEN_HI: begin
                if (accept_s) state_d = ST_LEN_LO;
                else          state_d = state_q;
            end
            ST_LEN_LO: begin
                if (!accept_s)                 state_d = state_q;
                else if (len_too_big_s)        state_d = ST_ERROR;
                else if (len_word_s == 16'd0)  state_d = ST_CSUM;
                else                           state_d = ST_DATA_HI;
            end
            ST_DATA_HI: begin
                if (accept_s) state_d = ST_DATA_LO;
                else          state_d = state_q;
            end
            ST_DATA_LO: begin
                if (!accept_s)                state_d = state_q;
                else if (cnt_next_s == len_q) state_d = ST_CSUM;
                else                          state_d = ST_DATA_HI;
            end
            ST_CSUM: begin
                if (!accept_s)              state_d = state_q;
                else if (sum_next_s == 8'h00) state_d = ST_DONE;
                else                        state_d = ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode, computed from the next state so the outputs are registered
    always_comb begin
        in_ready_d   = is_stream_state(state_d);
        cpu_hold_d   = 1'b1;
        load_done_d  = 1'b0;
        load_error_d = 1'b0;
        case (state_d)
            ST_DONE: begin
                cpu_hold_d  = 1'b0;
                load_done_d = 1'b1;
            end
            ST_ERROR: load_error_d = 1'b1;
            default: begin
                cpu_hold_d   = 1'b1;
                load_done_d  = 1'b0;
                load_error_d = 1'b0;
            end
        endcase
    end

    // Datapath: length capture, word counter, checksum and write address
    always_comb begin
        len_hi_d = len_hi_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        if (start_ok_s) begin
            sum_d = 8'h00;
            cnt_d = 16'd0;
        end else if (accept_s) begin
            sum_d = sum_next_s;
            case (state_q)
                ST_LEN_HI:  len_hi_d = in_data;
                ST_LEN_LO:  len_d    = len_word_s;
                ST_DATA_LO: begin
                    cnt_d  = cnt_next_s;
                    addr_d = ADDR_WIDTH'(BASE_ADDR) + cnt_q[ADDR_WIDTH-1:0];
                end
                default: cnt_d = cnt_q;
            endcase
        end else begin
            sum_d = sum_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi_q     <= 8'h00;
            len_q        <= 16'd0;
            cnt_q        <= 16'd0;
            sum_q        <= 8'h00;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            in_ready_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            addr_q       <= addr_d;
            in_ready_q   <= in_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    loader_byte_packer #(
        .WORD_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (reset),
        .hi_load    (accept_s & (state_q == ST_DATA_HI)),
        .lo_load    (accept_s & (state_q == ST_DATA_LO)),
        .byte_in    (in_data),
        .word_out   (mem_wdata),
        .word_valid (mem_we)
    );

    assign in_ready   = in_ready_q;
    assign mem_addr   = addr_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule
